sram_port_arbiter: RTL
======================

# sram_port_arbiter

Two-requester round-robin arbiter that shares one `single_port_memory_module` instance (synchronous write, one-cycle registered read) between two independent command sources. Each requester gets a valid/ready command handshake and a read-response channel. The arbiter registers the granted command onto the memory port and routes the returned read data back to the requester that issued it. It sits directly in front of the SRAM and is the only block driving its `we`/`addr`/`data_in` pins.

## Interface
- `width`, 32, data width; must match the SRAM `width`
- `depth`, 8, SRAM word count; power of two, at least 2
- `aw`, $clog2(depth) (3 at defaults), address width; derived localparam, not overridable

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid`  in  1  requester 0 presents a command
- `req0_we`  in  1  1 = write, 0 = read
- `req0_addr`  in  aw  word address
- `req0_wdata`  in  width  write data; ignored for reads
- `req0_ready`  out  1  command accepted this cycle when high together with `req0_valid`
- `rsp0_valid`  out  1  one-cycle pulse: `rsp0_rdata` holds read data for requester 0
- `rsp0_rdata`  out  width  read data
- `req1_valid`, `req1_we`, `req1_addr`, `req1_wdata`, `req1_ready`, `rsp1_valid`, `rsp1_rdata`: same as requester 0
- `mem_we`  out  1  to SRAM `we`
- `mem_addr`  out  aw  to SRAM `addr`
- `mem_data_in`  out  width  to SRAM `data_in`
- `mem_data_out`  in  width  from SRAM `data_out`

## Operation
- **Priority pointer `prio`:** 1 bit, reset 0, meaning requester 0 is favoured.
- **Grant logic (combinational):**
  - Only one `reqN_valid` high: grant N.
  - Both high: grant `prio`.
  - Neither high: no grant.
  - `reqN_ready` = grant to N. Both readies are forced 0 while `rst_n` is low.
- **Accept** = `reqN_valid & reqN_ready` at a rising edge. On accept:
  - `prio` becomes the non-granted index.
  - The command is registered into `mem_we`/`mem_addr`/`mem_data_in`.
- **No accept in a cycle:**
  - `mem_we` is registered to 0.
  - `mem_addr` and `mem_data_in` hold their previous values.
  - `prio` is unchanged.
- **Read tag pipeline:** for each registered read, a valid bit and a requester id are registered one edge later (the edge at which the SRAM samples the address). The valid bit drives `rspN_valid` for the tagged N.
- **Response data:** `rsp0_rdata` and `rsp1_rdata` are both wired directly to `mem_data_out`. They are meaningful only while the matching `rspN_valid` is high.
- **Writes** produce no response.
- **No response backpressure:** requesters must take `rspN_valid` data in the cycle it is shown.
- **Throughput:** one command per cycle, aggregate.
- **Fairness:** with both requesters continuously valid, grants alternate 0,1,0,1,... Neither requester waits more than 1 cycle.
- **Read after write, same address, back-to-back:** the read returns the newly written data, because the write commits at the edge where the read is registered.
- **Reset (asserted at any time, including mid-operation):** all registers clear immediately. In-flight reads are discarded, and no `rspN_valid` is raised for them after reset is released. SRAM contents are not touched.

## Timing
- **Reset values:**
  - `mem_we` = 0
  - `mem_addr` = 0
  - `mem_data_in` = 0
  - `rsp0_valid` = `rsp1_valid` = 0
  - `prio` = 0
  - tag valid = 0
- **Write accepted at edge E:**
  - `mem_we` = 1 from E to E+1.
  - SRAM commits at E+1.
- **Read accepted at edge E:**
  - `mem_addr` is driven from E.
  - SRAM registers the address at E+1 and `mem_data_out` updates after E+1.
  - `rspN_valid` is high for exactly the cycle between E+1 and E+2.
  - Load-to-response latency: 2 edges.
- **Back-to-back reads** at E and E+1 give responses in consecutive cycles, in accept order.
- **`reqN_ready`** is combinational from `reqN_valid` and `prio` only. There is no path from `mem_data_out` to any ready.

## Test plan
- **Single-requester write then read:**
  - Stimulus: reset; req0 writes 32'hA5A5A5A5 to addr 3; next cycle req0 reads addr 3.
  - Required: `rsp0_valid` pulses exactly 2 edges after the read is accepted, with `rsp0_rdata` = 32'hA5A5A5A5; `rsp1_valid` stays 0.
- **Contention alternation:**
  - Stimulus: both requesters hold `valid` high for 6 cycles with writes to addresses 0..5.
  - Required: grant order 0,1,0,1,0,1 (`prio` starts at 0).
  - Read-back of all six addresses returns the data of the writer granted for each.
- **Response routing:**
  - Stimulus: req0 reads addr 1 (holding 32'h11111111) at edge E; req1 reads addr 2 (holding 32'h22222222) at edge E+1.
  - Required: `rsp0_valid` high in cycle E+1..E+2 with 32'h11111111; `rsp1_valid` high in cycle E+2..E+3 with 32'h22222222; never both high together.
- **Read-after-write hazard:**
  - Stimulus: req1 writes 32'hDEADBEEF to addr 7 at edge E; req0 reads addr 7 at edge E+1.
  - Required: `rsp0_rdata` = 32'hDEADBEEF.
- **Reset mid-read:**
  - Stimulus: read accepted at edge E; `rst_n` pulled low between E and E+1, released 2 cycles later.
  - Required: no `rspN_valid` ever appears for that read; all outputs at reset values while low; `prio` = 0 after release.
- **Idle:**
  - Stimulus: no valids for 5 cycles.
  - Required: `mem_we` = 0 and `mem_addr` unchanged throughout.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM with a
// one-cycle registered read; read data is steered back via a tag pipeline.
module sram_port_arbiter #(
    parameter int width = 32,
    parameter int depth = 8,
    localparam int aw = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [aw-1:0]    req0_addr,
    input  logic [width-1:0] req0_wdata,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [width-1:0] rsp0_rdata,

    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [aw-1:0]    req1_addr,
    input  logic [width-1:0] req1_wdata,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [width-1:0] rsp1_rdata,

    output logic             mem_we,
    output logic [aw-1:0]    mem_addr,
    output logic [width-1:0] mem_data_in,
    input  logic [width-1:0] mem_data_out
);

    // Handshake: a command transfers on a rising edge where reqN_valid and
    // reqN_ready are both high; ready never depends on mem_data_out, and
    // responses (rspN_valid) are single-cycle pulses with no backpressure.

    logic prio;
    logic gnt0, gnt1;
    logic acc0, acc1;

    // Read issued to the SRAM this cycle, and who issued it
    logic rd_pend;
    logic rd_id;

    // Tag aligned with mem_data_out
    logic tag_valid;
    logic tag_id;

    always_comb begin
        gnt0 = req0_valid & (~req1_valid | ~prio);
        gnt1 = req1_valid & (~req0_valid |  prio);
    end

    assign req0_ready = gnt0 & rst_n;
    assign req1_ready = gnt1 & rst_n;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rd_pend     <= 1'b0;
            rd_id       <= 1'b0;
            tag_valid   <= 1'b0;
            tag_id      <= 1'b0;
        end else begin
            if (acc1) begin
                prio        <= 1'b0;
                mem_we      <= req1_we;
                mem_addr    <= req1_addr;
                mem_data_in <= req1_wdata;
                rd_pend     <= ~req1_we;
                rd_id       <= 1'b1;
            end else if (acc0) begin
                prio        <= 1'b1;
                mem_we      <= req0_we;
                mem_addr    <= req0_addr;
                mem_data_in <= req0_wdata;
                rd_pend     <= ~req0_we;
                rd_id       <= 1'b0;
            end else begin
                mem_we  <= 1'b0;
                rd_pend <= 1'b0;
            end
            tag_valid <= rd_pend;
            tag_id    <= rd_id;
        end
    end

    assign rsp0_valid = tag_valid & ~tag_id;
    assign rsp1_valid = tag_valid &  tag_id;
    assign rsp0_rdata = mem_data_out;
    assign rsp1_rdata = mem_data_out;

endmodule
